// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants for the writeback stage: load funct3 codes,
//               FSM state encoding and default datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_if
// Description : MEM->WB handshake, data-memory response and register-file /
//               forwarding write port of the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_stage_if
    import wb_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rd;
    logic              in_rd_we;
    logic              in_is_load;
    logic [2:0]        in_funct3;
    logic [1:0]        in_addr_lo;
    logic [XLEN-1:0]   in_alu_result;

    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;

    // Upstream / environment side
    modport master (
        output in_valid, in_rd, in_rd_we, in_is_load, in_funct3, in_addr_lo,
               in_alu_result, dmem_rvalid, dmem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data
    );

    // Writeback stage side
    modport slave (
        input  in_valid, in_rd, in_rd_we, in_is_load, in_funct3, in_addr_lo,
               in_alu_result, dmem_rvalid, dmem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data
    );

endinterface
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational load-data alignment and sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import wb_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  wire logic [XLEN-1:0] i_rdata,
    input  wire logic [2:0]      i_funct3,
    input  wire logic [1:0]      i_addr_lo,
    output logic      [XLEN-1:0] o_result
);

    logic [XLEN-1:0] w_byte_sh;
    logic [XLEN-1:0] w_half_sh;

    // Bring the addressed lane down to bit 0; halfwords only use addr_lo[1]
    assign w_byte_sh = i_rdata >> {i_addr_lo, 3'b000};
    assign w_half_sh = i_rdata >> {i_addr_lo[1], 4'b0000};

    always_comb begin
        o_result = i_rdata;
        case (i_funct3)
            F3_LB:   o_result = {{(XLEN-8){w_byte_sh[7]}}, w_byte_sh[7:0]};
            F3_LBU:  o_result = {{(XLEN-8){1'b0}}, w_byte_sh[7:0]};
            F3_LH:   o_result = {{(XLEN-16){w_half_sh[15]}}, w_half_sh[15:0]};
            F3_LHU:  o_result = {{(XLEN-16){1'b0}}, w_half_sh[15:0]};
            F3_LW:   o_result = i_rdata;
            default: o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Writeback stage: accepts retiring instructions, waits for load
//               data, drives the register-file write port and forwarding copy.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wb_stage_if.slave        bus,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             err_rvalid
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]        r_state;
    logic [REG_AW-1:0] r_rd;
    logic              r_rd_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;

    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic              r_err_rvalid;

    logic              w_accept;
    logic [XLEN-1:0]   w_load_data;

    assign bus.in_ready = (r_state == IDLE);
    assign w_accept     = bus.in_valid & bus.in_ready;

    load_extract #(
        .XLEN (XLEN)
    ) u_load_extract (
        .i_rdata   (bus.dmem_rdata),
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .o_result  (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rd         <= '0;
            r_rd_we      <= 1'b0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_retire_cnt <= '0;
            r_err_rvalid <= 1'b0;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A response with no load outstanding is a protocol error
                    if (bus.dmem_rvalid) begin
                        r_err_rvalid <= 1'b1;
                    end
                    if (w_accept) begin
                        if (bus.in_is_load) begin
                            r_rd      <= bus.in_rd;
                            r_rd_we   <= bus.in_rd_we;
                            r_funct3  <= bus.in_funct3;
                            r_addr_lo <= bus.in_addr_lo;
                            r_state   <= WAIT_LOAD;
                        end else begin
                            r_rf_we      <= bus.in_rd_we & (|bus.in_rd);
                            r_rf_waddr   <= bus.in_rd;
                            r_rf_wdata   <= bus.in_alu_result;
                            r_retire_cnt <= r_retire_cnt + c_cnt_one;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (bus.dmem_rvalid) begin
                        r_rf_we      <= r_rd_we & (|r_rd);
                        r_rf_waddr   <= r_rd;
                        r_rf_wdata   <= w_load_data;
                        r_retire_cnt <= r_retire_cnt + c_cnt_one;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rf_we     = r_rf_we;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.fwd_valid = r_rf_we;
    assign bus.fwd_rd    = r_rf_waddr;
    assign bus.fwd_data  = r_rf_wdata;
    assign retire_cnt    = r_retire_cnt;
    assign err_rvalid    = r_err_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking directed bench for wb_stage (4-bit retire counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;
    import wb_pkg::*;

    localparam int TB_CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [TB_CNT_W-1:0] retire_cnt;
    logic                err_rvalid;

    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    wb_stage #(
        .XLEN   (32),
        .REG_AW (5),
        .CNT_W  (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .retire_cnt (retire_cnt),
        .err_rvalid (err_rvalid)
    );

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic        rd_we;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] alu;
        logic [31:0] rdata;
        int          lat;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vec[12];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cnt_m  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic we, input logic [4:0] rd,
                                 input logic [31:0] data);
        chk({tag, " rf_we"}, 32'(bus.rf_we), 32'(we));
        chk({tag, " fwd_valid"}, 32'(bus.fwd_valid), 32'(we));
        if (we) begin
            chk({tag, " rf_waddr"}, 32'(bus.rf_waddr), 32'(rd));
            chk({tag, " rf_wdata"}, bus.rf_wdata, data);
            chk({tag, " fwd_rd"}, 32'(bus.fwd_rd), 32'(rd));
            chk({tag, " fwd_data"}, bus.fwd_data, data);
        end
    endtask

    initial begin
        int busy;
        //                 load rd    we    funct3 lo    alu           rdata        lat we  wdata
        vec[0]  = '{1'b0, 5'd5,  1'b1, F3_LW,  2'd0, 32'hDEADBEEF, 32'h0,        0, 1'b1, 32'hDEADBEEF};
        vec[1]  = '{1'b1, 5'd3,  1'b1, F3_LB,  2'd2, 32'h0,        32'h12805634, 4, 1'b1, 32'hFFFFFF80};
        vec[2]  = '{1'b1, 5'd3,  1'b1, F3_LBU, 2'd2, 32'h0,        32'h12805634, 4, 1'b1, 32'h00000080};
        vec[3]  = '{1'b1, 5'd6,  1'b1, F3_LH,  2'd2, 32'h0,        32'h80011234, 1, 1'b1, 32'hFFFF8001};
        vec[4]  = '{1'b1, 5'd7,  1'b1, F3_LHU, 2'd3, 32'h0,        32'h80011234, 0, 1'b1, 32'h00008001};
        vec[5]  = '{1'b1, 5'd8,  1'b1, F3_LW,  2'd1, 32'h0,        32'hCAFEF00D, 2, 1'b1, 32'hCAFEF00D};
        vec[6]  = '{1'b1, 5'd9,  1'b1, 3'b011, 2'd2, 32'h0,        32'h11223344, 0, 1'b1, 32'h11223344};
        vec[7]  = '{1'b1, 5'd10, 1'b1, F3_LB,  2'd0, 32'h0,        32'h0000007F, 0, 1'b1, 32'h0000007F};
        vec[8]  = '{1'b1, 5'd11, 1'b1, F3_LH,  2'd0, 32'h0,        32'h0000ABCD, 1, 1'b1, 32'hFFFFABCD};
        vec[9]  = '{1'b1, 5'd12, 1'b1, F3_LBU, 2'd3, 32'h0,        32'hA5000000, 0, 1'b1, 32'h000000A5};
        vec[10] = '{1'b0, 5'd0,  1'b1, F3_LW,  2'd0, 32'h00000055, 32'h0,        0, 1'b0, 32'h0};
        vec[11] = '{1'b0, 5'd13, 1'b0, F3_LW,  2'd0, 32'h00000001, 32'h0,        0, 1'b0, 32'h0};

        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_rd         = '0;
        bus.in_rd_we      = 1'b0;
        bus.in_is_load    = 1'b0;
        bus.in_funct3     = '0;
        bus.in_addr_lo    = '0;
        bus.in_alu_result = '0;
        bus.dmem_rvalid   = 1'b0;
        bus.dmem_rdata    = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset rf_we", 32'(bus.rf_we), 32'd0);
        chk("reset rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("reset rf_wdata", bus.rf_wdata, 32'd0);
        chk("reset retire_cnt", 32'(retire_cnt), 32'd0);
        chk("reset err_rvalid", 32'(err_rvalid), 32'd0);

        // Table: one instruction per entry, load data after 'lat' idle cycles
        for (int i = 0; i < 12; i++) begin
            bus.in_valid      = 1'b1;
            bus.in_rd         = vec[i].rd;
            bus.in_rd_we      = vec[i].rd_we;
            bus.in_is_load    = vec[i].is_load;
            bus.in_funct3     = vec[i].funct3;
            bus.in_addr_lo    = vec[i].addr_lo;
            bus.in_alu_result = vec[i].alu;
            tick();
            bus.in_valid = 1'b0;
            if (vec[i].is_load) begin
                busy = 0;
                for (int w = 0; w < vec[i].lat; w++) begin
                    if (!bus.in_ready) busy++;
                    chk($sformatf("vec%0d wait rf_we", i), 32'(bus.rf_we), 32'd0);
                    tick();
                end
                bus.dmem_rvalid = 1'b1;
                bus.dmem_rdata  = vec[i].rdata;
                if (!bus.in_ready) busy++;
                tick();
                bus.dmem_rvalid = 1'b0;
                chk($sformatf("vec%0d busy cycles", i), 32'(busy), 32'(vec[i].lat + 1));
                chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            end
            cnt_m = (cnt_m + 1) % 16;
            check_outputs($sformatf("vec%0d", i), vec[i].exp_we, vec[i].rd, vec[i].exp_wdata);
            chk($sformatf("vec%0d retire_cnt", i), 32'(retire_cnt), 32'(cnt_m));
        end
        tick();
        chk("idle rf_we pulse ends", 32'(bus.rf_we), 32'd0);
        chk("no spurious err_rvalid", 32'(err_rvalid), 32'd0);

        // Ten back-to-back non-loads, then six more to wrap the 4-bit counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt_m = 0;
        bus.in_is_load = 1'b0;
        bus.in_rd_we   = 1'b1;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_rd         = 5'(i + 1);
            bus.in_alu_result = 32'h100 + 32'(i);
            tick();
            cnt_m = (cnt_m + 1) % 16;
            check_outputs($sformatf("b2b%0d", i), 1'b1, 5'(i + 1), 32'h100 + 32'(i));
            if (i == 9) chk("b2b retire_cnt=10", 32'(retire_cnt), 32'd10);
        end
        bus.in_valid = 1'b0;
        chk("wrap retire_cnt", 32'(retire_cnt), 32'd0);
        tick();
        chk("b2b rf_we drops", 32'(bus.rf_we), 32'd0);

        // Non-load held valid behind a pending load retires only after it
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b1;
        bus.in_rd      = 5'd9;
        bus.in_funct3  = F3_LW;
        bus.in_addr_lo = 2'd0;
        tick();
        bus.in_is_load    = 1'b0;
        bus.in_rd         = 5'd10;
        bus.in_alu_result = 32'h00000A0A;
        tick();
        chk("order in_ready low", 32'(bus.in_ready), 32'd0);
        chk("order no early write", 32'(bus.rf_we), 32'd0);
        tick();
        chk("order still blocked", 32'(bus.rf_we), 32'd0);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h99887766;
        tick();
        bus.dmem_rvalid = 1'b0;
        check_outputs("order load", 1'b1, 5'd9, 32'h99887766);
        chk("order ready after rvalid", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check_outputs("order nonload", 1'b1, 5'd10, 32'h00000A0A);
        chk("order retire_cnt", 32'(retire_cnt), 32'd2);

        // Reset during WAIT_LOAD drops the load; the late response is an error
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b1;
        bus.in_rd      = 5'd4;
        bus.in_funct3  = F3_LW;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h0BADF00D;
        tick();
        bus.dmem_rvalid = 1'b0;
        chk("rstload rf_we", 32'(bus.rf_we), 32'd0);
        chk("rstload retire_cnt", 32'(retire_cnt), 32'd0);
        chk("rstload err_rvalid", 32'(err_rvalid), 32'd1);
        chk("rstload in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("err_rvalid sticky", 32'(err_rvalid), 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
